// File: rtl/ex_mem_boot_pkg.sv
// Shared definitions for the external-memory boot loader.
//   loader_state_t : sequencer states
//   ADDR_W_DEF / DATA_W_DEF : default ExMem address / word widths
//   PAIR_STRIDE    : address step between consecutive word pairs
package ex_mem_boot_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int PAIR_STRIDE = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD_INST,
    S_LOAD_DATA,
    S_SETTLE,
    S_RUN
  } loader_state_t;

endpackage

// File: rtl/ex_mem_pair_packer.sv
// Packs a stream of words into (even, odd) pairs and drives them, together
// with the pair address, onto either the Inst or the Data ExMem outputs.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : zero all outputs, pending word and address counter
//   sel          : 0 steers pairs to inst_*, 1 to data_*
//   wr           : a stream word is accepted this cycle
//   last         : the accepted word is the final word of the current image
//   wdata        : accepted word
//   inst_*/data_*: registered pair outputs (address, even word, odd word)
module ex_mem_pair_packer
  import ex_mem_boot_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              sel,
  input  logic              wr,
  input  logic              last,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_d1,
  output logic [DATA_W-1:0] inst_d2,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_d1,
  output logic [DATA_W-1:0] data_d2
);

  logic [DATA_W-1:0] pending;
  logic              odd;       // an even word is parked in pending
  logic [ADDR_W-1:0] addr_cnt;  // address of the pair being built
  logic              flush;
  logic [DATA_W-1:0] pair_d1;
  logic [DATA_W-1:0] pair_d2;

  // A pair is emitted on its odd word, or on an even word that ends the
  // image; the latter gets a zero partner.
  assign flush   = odd || last;
  assign pair_d1 = odd ? pending : wdata;
  assign pair_d2 = odd ? wdata : '0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pending   <= '0;
      odd       <= 1'b0;
      addr_cnt  <= '0;
      inst_addr <= '0;
      inst_d1   <= '0;
      inst_d2   <= '0;
      data_addr <= '0;
      data_d1   <= '0;
      data_d2   <= '0;
    end else if (wr) begin
      if (flush) begin
        odd <= 1'b0;
        // Rewind at the end of an image so the next image starts at 0.
        addr_cnt <= last ? '0 : addr_cnt + ADDR_W'(PAIR_STRIDE);
        if (sel) begin
          data_addr <= addr_cnt;
          data_d1   <= pair_d1;
          data_d2   <= pair_d2;
        end else begin
          inst_addr <= addr_cnt;
          inst_d1   <= pair_d1;
          inst_d2   <= pair_d2;
        end
      end else begin
        pending <= wdata;
        odd     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_mem_boot_loader.sv
// Boot sequencer for the core's external-memory load port. Holds the core
// in reset, streams the instruction image then the data image in word
// pairs onto the Inst/Data ExMem ports, then releases the core.
//   clk, reset          : clock, synchronous active-high reset
//   start               : load request (IDLE/RUN only), with inst_count and
//                         data_count word counts (each <= 2^ADDR_W)
//   s_valid/s_data/s_ready : word stream handshake
//   core_reset, enable_load_ex_mem : core reset and external-load enable
//   Inst*/Data*         : pair address, even word, odd word per image
//   busy/done/err       : loading, core running, start rejected (pulse)
module ex_mem_boot_loader
  import ex_mem_boot_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = 10,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  inst_count,
  input  logic [CNT_W-1:0]  data_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              core_reset,
  output logic              enable_load_ex_mem,
  output logic [ADDR_W-1:0] InstExMemAddress,
  output logic [DATA_W-1:0] InstExMemData1,
  output logic [DATA_W-1:0] InstExMemData2,
  output logic [ADDR_W-1:0] DataExMemAddress,
  output logic [DATA_W-1:0] DataExMemData1,
  output logic [DATA_W-1:0] DataExMemData2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1 << ADDR_W);

  loader_state_t     state;
  logic [CNT_W-1:0]  ic_q;
  logic [CNT_W-1:0]  dc_q;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  cur_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              drain;     // final word taken, one cycle to present it
  logic              xfer;
  logic              last_word;
  logic              counts_ok;
  logic              start_ok;

  assign xfer      = s_valid && s_ready;
  assign cur_cnt   = (state == S_LOAD_DATA) ? dc_q : ic_q;
  assign last_word = (wcnt == cur_cnt - CNT_W'(1));
  assign counts_ok = (inst_count <= MAX_WORDS) && (data_count <= MAX_WORDS);
  assign start_ok  = start && counts_ok && (state == S_IDLE || state == S_RUN);

  ex_mem_pair_packer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .sel       (state == S_LOAD_DATA),
    .wr        (xfer),
    .last      (last_word),
    .wdata     (s_data),
    .inst_addr (InstExMemAddress),
    .inst_d1   (InstExMemData1),
    .inst_d2   (InstExMemData2),
    .data_addr (DataExMemAddress),
    .data_d1   (DataExMemData1),
    .data_d2   (DataExMemData2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      core_reset         <= 1'b1;
      enable_load_ex_mem <= 1'b0;
      s_ready            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      ic_q               <= '0;
      dc_q               <= '0;
      wcnt               <= '0;
      hold_cnt           <= '0;
      drain              <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (start) begin
            if (counts_ok) begin
              state              <= S_HOLD;
              ic_q               <= inst_count;
              dc_q               <= data_count;
              wcnt               <= '0;
              hold_cnt           <= '0;
              drain              <= 1'b0;
              core_reset         <= 1'b1;
              enable_load_ex_mem <= 1'b1;
              busy               <= 1'b1;
              done               <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
            if (ic_q != '0) begin
              state   <= S_LOAD_INST;
              s_ready <= 1'b1;
            end else if (dc_q != '0) begin
              state   <= S_LOAD_DATA;
              s_ready <= 1'b1;
            end else begin
              state              <= S_SETTLE;
              enable_load_ex_mem <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        // The final pair lands on the edge that accepts the last word; the
        // drain cycle keeps enable high so the core samples that pair
        // before SETTLE drops enable. This gives the 2-cycle release.
        S_LOAD_INST, S_LOAD_DATA: begin
          if (drain) begin
            state              <= S_SETTLE;
            enable_load_ex_mem <= 1'b0;
            drain              <= 1'b0;
          end else if (xfer) begin
            if (last_word) begin
              wcnt <= '0;
              if (state == S_LOAD_INST && dc_q != '0) begin
                state <= S_LOAD_DATA;
              end else begin
                drain   <= 1'b1;
                s_ready <= 1'b0;
              end
            end else begin
              wcnt <= wcnt + CNT_W'(1);
            end
          end
        end

        S_SETTLE: begin
          state      <= S_RUN;
          core_reset <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_mem_boot_loader.md
Name: ex_mem_boot_loader

Overview:
- Boot sequencer for the core's external-memory load port.
- Accepts a stream of 32-bit words over a valid/ready handshake and packs them into word pairs. Drives the instruction image into the Inst port, then the data image into the Data port.
- Holds the core in reset while loading, then releases it to run.
- Sits between the bench/host and the riscv top-level; it replaces the hand-driven enable/address/data sequence.

Parameters:
- ADDR_W, 9, width of Inst/Data ExMem address ports (word address).
- DATA_W, 32, word width.
- CNT_W, 10, width of word-count inputs.
- RST_CYCLES, 2, cycles core_reset is held in HOLD before loading starts (>=1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a load; sampled in IDLE or RUN only
- inst_count  in  CNT_W  number of instruction words; sampled on accepted start
- data_count  in  CNT_W  number of data words; sampled on accepted start
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_ready  out  1  stream word accepted when s_valid && s_ready
- core_reset  out  1  reset to riscv core
- enable_load_ex_mem  out  1  core external-load enable
- InstExMemAddress  out  ADDR_W  address of InstExMemData1 word
- InstExMemData1  out  DATA_W  even word of the pair
- InstExMemData2  out  DATA_W  odd word of the pair
- DataExMemAddress  out  ADDR_W  address of DataExMemData1 word
- DataExMemData1  out  DATA_W  even word of the pair
- DataExMemData2  out  DATA_W  odd word of the pair
- busy  out  1  high in HOLD, LOAD_INST, LOAD_DATA, SETTLE
- done  out  1  high in RUN
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: state=IDLE; core_reset=1; enable_load_ex_mem=0; s_ready=0; all address/data outputs 0; busy=0; done=0; err=0.
- States: IDLE, HOLD, LOAD_INST, LOAD_DATA, SETTLE, RUN.
- Start acceptance and rejection:
  - start is accepted in IDLE/RUN when inst_count<=2^ADDR_W and data_count<=2^ADDR_W.
  - An out-of-range count rejects start: err pulses 1 cycle and the state is unchanged.
  - start is ignored in all other states.
- Accepted start:
  - Latches both counts and clears addresses, data and word counters.
  - Next state HOLD; core_reset=1, enable_load_ex_mem=1.
- HOLD:
  - Lasts exactly RST_CYCLES cycles.
  - Then goes to LOAD_INST, or to LOAD_DATA if inst_count==0, or to SETTLE if both counts are 0.
- LOAD_* handshake:
  - s_ready=1 for the whole state; a word is transferred on s_valid&&s_ready.
  - An even-index word goes to a pending register; outputs are unchanged.
  - An odd-index word, or the last word of an odd count, updates Addr/Data1/Data2 atomically on the next edge.
  - Data2 is forced to 0 for an odd final word.
  - After each pair update the address advances by 2. The first pair uses address 0.
  - Pair outputs hold stable between updates; repeated sampling by the core is idempotent.
- Phase transitions:
  - After the last inst word, the Inst outputs hold and the state goes to LOAD_DATA (or SETTLE if data_count==0).
  - After the last data word, the state goes to SETTLE.
  - s_ready drops in the cycle after the last transfer of the final phase.
- SETTLE:
  - Lasts 1 cycle; enable_load_ex_mem=0, core_reset=1.
  - Then RUN: core_reset=0, done=1, busy=0.
- IDLE: core_reset=1, enable_load_ex_mem=0.
- Latency: the core leaves reset exactly 2 cycles after the edge that accepts the final word.
- Address wrap: cannot occur; the range check guarantees max address 2^ADDR_W-2.
- reset mid-load: return to IDLE with reset values; partial pairs are discarded.
- Simultaneous start with reset: reset wins.

Decomposition:
- Package ex_mem_boot_pkg holds:
  - state enum loader_state_t;
  - DATA_W/ADDR_W defaults;
  - PAIR_STRIDE=2.
- One sub-module, ex_mem_pair_packer: pending-word register, pair assembly, odd-tail zero pad and address counter. Instantiated once, with a select that steers to the Inst or Data outputs.
- FSM and counters stay in the top.

Test Plan:
- Reset, then start with inst_count=2, data_count=2. Stream 0x00100393, 0x00038303, 0x00008F00, 0x000000FF, s_valid always 1.
  - InstAddr=0, Data1=0x00100393, Data2=0x00038303.
  - DataAddr=0, Data1=0x00008F00, Data2=0x000000FF.
  - enable drops, and core_reset=0 two cycles after the last word.
- inst_count=3, data_count=0, stream A,B,C.
  - Inst pairs (0:A,B) then (2:C,0).
  - LOAD_DATA is skipped; done=1.
- Same as the first scenario with s_valid toggling 1,0,0,1 per cycle.
  - Identical final outputs; no output change on idle cycles.
  - s_ready stays 1 throughout the load.
- start with inst_count=513 -> err one-cycle pulse; state stays IDLE; core_reset=1; s_ready=0.
- reset asserted after 1 of 4 words.
  - All outputs return to reset values next edge.
  - A new start with counts 1/1 loads fresh: InstAddr 0 (W,0), DataAddr 0 (X,0).
- start while in RUN with counts 2/0 -> core_reset reasserts, reload completes, done returns to 1.
